fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port (wr/din) of the synchronous FIFO between NREQ independent producers.
- Each producer uses a req/ack handshake. The winner holds the grant for a burst of up to MAXBURST beats, then rotates.
- Sits directly in front of the FIFO write side, observes full, and never issues wr while full=1.

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 136 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int NREQ_DEF     = 4;
    localparam int DW_DEF       = 8;
    localparam int MAXBURST_DEF = 4;

    // Width of a counter/index holding values 0..n-1, never narrower than 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit at or above start, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   start_i,
    output logic            found_o,
    output logic [IW-1:0]   idx_o
);

    logic [IW-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(start_i) + k) % NREQ);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ req/ack producers.
// Define ARB_STATS_EN to add the stall_cnt output (grant cycles blocked by full).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAXBURST = MAXBURST_DEF,
    localparam int IW      = idx_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    input  logic              full,
    output logic              wr,
    output logic [DW-1:0]     din,
    output logic              gnt_valid,
    output logic [IW-1:0]     gnt_idx,
    output logic              dbg_state_o
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int CW = idx_width(MAXBURST);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;

    logic [IW-1:0] g_next;
    logic [IW-1:0] pick_start;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          req_g;
    logic [DW-1:0] data_g;
    logic          last_beat;

    assign g_next = (gnt_idx_q == IW'(NREQ - 1)) ? '0 : gnt_idx_q + 1'b1;
    // While granted, the search starts just past the holder so it is considered last.
    assign pick_start = (state_q == ARB_GRANT) ? g_next : rr_ptr_q;
    assign req_g      = req[gnt_idx_q];

    always_comb begin
        data_g = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx_q == IW'(i)) data_g = req_data[i*DW +: DW];
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req_i   (req),
        .start_i (pick_start),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            gnt_idx_q  <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        wr         = 1'b0;
        ack        = '0;
        din        = '0;
        gnt_valid  = 1'b0;
        last_beat  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    gnt_idx_d  = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                gnt_valid = 1'b1;
                din       = data_g;
                wr        = req_g & ~full;
                ack       = NREQ'(wr) << gnt_idx_q;
                last_beat = wr && (beat_cnt_q == CW'(MAXBURST - 1));
                if (last_beat || !req_g) begin
                    rr_ptr_d = g_next;
                    if (pick_found) begin
                        gnt_idx_d  = pick_idx;
                        beat_cnt_d = '0;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (wr) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign gnt_idx     = gnt_idx_q;
    assign dbg_state_o = state_q;

`ifdef ARB_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (state_q == ARB_GRANT && req_g && full && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed vector bench for fifo_wr_arbiter (NREQ=4, DW=8, MAXBURST=4).
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        full;
    logic        wr;
    logic [7:0]  din;
    logic        gnt_valid;
    logic [1:0]  gnt_idx;
    logic        dbg_state;
`ifdef ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int n_total;
    int n_pass;

    fifo_wr_arbiter #(.NREQ(4), .DW(8), .MAXBURST(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .full        (full),
        .wr          (wr),
        .din         (din),
        .gnt_valid   (gnt_valid),
        .gnt_idx     (gnt_idx),
        .dbg_state_o (dbg_state)
`ifdef ARB_STATS_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        full;
        logic        wr;
        logic [3:0]  ack;
        logic        gv;
        logic [1:0]  gi;
        logic [7:0]  din;
        logic [15:0] stall;
    } vec_t;

    vec_t vecs[64];
    int   nvec;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL step%0d %s: got %0h, expected %0h", id, name, act, exp);
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic f, input logic w,
                       input logic [3:0] a, input logic gv, input logic [1:0] gi,
                       input logic [7:0] d, input logic [15:0] st);
        vecs[nvec].rst   = r;
        vecs[nvec].req   = rq;
        vecs[nvec].full  = f;
        vecs[nvec].wr    = w;
        vecs[nvec].ack   = a;
        vecs[nvec].gv    = gv;
        vecs[nvec].gi    = gi;
        vecs[nvec].din   = d;
        vecs[nvec].stall = st;
        nvec++;
    endtask

    // Called just after a rising edge: drive, check at the falling edge, advance one cycle.
    task automatic run_vec(input vec_t v, input int id);
        rst  = v.rst;
        req  = v.req;
        full = v.full;
        @(negedge clk);
        chk("wr", id, 32'(wr), 32'(v.wr));
        chk("ack", id, 32'(ack), 32'(v.ack));
        chk("gnt_valid", id, 32'(gnt_valid), 32'(v.gv));
        if (v.gv) chk("gnt_idx", id, 32'(gnt_idx), 32'(v.gi));
        chk("din", id, 32'(din), 32'(v.din));
`ifdef ARB_STATS_EN
        chk("stall_cnt", id, 32'(stall_cnt), 32'(v.stall));
`endif
        @(posedge clk);
        #1;
    endtask

    vec_t h;

    initial begin
        n_total  = 0;
        n_pass   = 0;
        nvec     = 0;
        rst      = 1'b0;
        req      = 4'b0000;
        full     = 1'b0;
        req_data = {8'hD3, 8'hC2, 8'h11, 8'hA0};

        // Reset with all requesters asserted, then first grant to idx 0.
        add(0, 4'b1111, 0, 0, 4'b0000, 0, 0, 8'h00, 0);
        add(0, 4'b1111, 0, 0, 4'b0000, 0, 0, 8'h00, 0);
        add(1, 4'b1111, 0, 0, 4'b0000, 0, 0, 8'h00, 0);
        add(1, 4'b1111, 0, 1, 4'b0001, 1, 0, 8'hA0, 0);
        // Single requester 1: back-to-back bursts with no bubble.
        add(0, 4'b0010, 0, 0, 4'b0000, 0, 0, 8'h00, 0);
        add(1, 4'b0010, 0, 0, 4'b0000, 0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) add(1, 4'b0010, 0, 1, 4'b0010, 1, 1, 8'h11, 0);
        // Fairness between 0 and 2.
        add(0, 4'b0101, 0, 0, 4'b0000, 0, 0, 8'h00, 0);
        add(1, 4'b0101, 0, 0, 4'b0000, 0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) add(1, 4'b0101, 0, 1, 4'b0001, 1, 0, 8'hA0, 0);
        for (int i = 0; i < 4; i++) add(1, 4'b0101, 0, 1, 4'b0100, 1, 2, 8'hC2, 0);
        add(1, 4'b0101, 0, 1, 4'b0001, 1, 0, 8'hA0, 0);
        // Backpressure: 2 beats, 3 full cycles, 2 beats, rotate to 1.
        add(0, 4'b0011, 0, 0, 4'b0000, 0, 0, 8'h00, 0);
        add(1, 4'b0011, 0, 0, 4'b0000, 0, 0, 8'h00, 0);
        add(1, 4'b0011, 0, 1, 4'b0001, 1, 0, 8'hA0, 0);
        add(1, 4'b0011, 0, 1, 4'b0001, 1, 0, 8'hA0, 0);
        add(1, 4'b0011, 1, 0, 4'b0000, 1, 0, 8'hA0, 0);
        add(1, 4'b0011, 1, 0, 4'b0000, 1, 0, 8'hA0, 1);
        add(1, 4'b0011, 1, 0, 4'b0000, 1, 0, 8'hA0, 2);
        add(1, 4'b0011, 0, 1, 4'b0001, 1, 0, 8'hA0, 3);
        add(1, 4'b0011, 0, 1, 4'b0001, 1, 0, 8'hA0, 3);
        add(1, 4'b0011, 0, 1, 4'b0010, 1, 1, 8'h11, 3);
        // Early drop of req[3] after 2 beats, handover to 1, then IDLE pick from rr_ptr=2.
        add(0, 4'b1000, 0, 0, 4'b0000, 0, 0, 8'h00, 0);
        add(1, 4'b1000, 0, 0, 4'b0000, 0, 0, 8'h00, 0);
        add(1, 4'b1010, 0, 1, 4'b1000, 1, 3, 8'hD3, 0);
        add(1, 4'b1010, 0, 1, 4'b1000, 1, 3, 8'hD3, 0);
        add(1, 4'b0010, 0, 0, 4'b0000, 1, 3, 8'hD3, 0);
        add(1, 4'b0010, 0, 1, 4'b0010, 1, 1, 8'h11, 0);
        add(1, 4'b0000, 0, 0, 4'b0000, 1, 1, 8'h11, 0);
        add(1, 4'b0110, 0, 0, 4'b0000, 0, 0, 8'h00, 0);
        add(1, 4'b0110, 0, 1, 4'b0100, 1, 2, 8'hC2, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < nvec; i++) run_vec(vecs[i], i);

        // Asynchronous reset in the middle of a second burst on idx 2.
        h = '{rst: 0, req: 4'b0100, full: 0, wr: 0, ack: 4'b0000, gv: 0, gi: 0, din: 8'h00, stall: 0};
        run_vec(h, 100);
        h.rst = 1;
        run_vec(h, 101);
        h = '{rst: 1, req: 4'b0100, full: 0, wr: 1, ack: 4'b0100, gv: 1, gi: 2, din: 8'hC2, stall: 0};
        for (int i = 0; i < 5; i++) run_vec(h, 102 + i);
        #2;
        chk("pre_reset_wr", 107, 32'(wr), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_wr", 108, 32'(wr), 32'd0);
        chk("async_ack", 108, 32'(ack), 32'd0);
        chk("async_gnt_valid", 108, 32'(gnt_valid), 32'd0);
        chk("async_din", 108, 32'(din), 32'd0);
        @(posedge clk);
        #1;
        h = '{rst: 1, req: 4'b1111, full: 0, wr: 0, ack: 4'b0000, gv: 0, gi: 0, din: 8'h00, stall: 0};
        run_vec(h, 109);
        h = '{rst: 1, req: 4'b1111, full: 0, wr: 1, ack: 4'b0001, gv: 1, gi: 0, din: 8'hA0, stall: 0};
        run_vec(h, 110);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
